// File: rtl/dma_rxbuf_sched.sv
// dma_rxbuf_sched
// Receive-buffer scheduler for the DMA engine. Keeps a ring of SLOT_NUM packet
// buffers in data RAM and posts free slots as {length, addr} descriptors into the
// pBufWR FIFO. CPU-posted descriptors share the FIFO write port with fixed priority.
// Completions (engine write done) and CPU releases advance the ring; disabling the
// engine drains outstanding descriptors before returning to idle.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_enable              1 = run refill engine, 0 = drain
//   i_cpu_wren_pBufWR     CPU descriptor write strobe
//   i_cpu_din_pBufWR      CPU descriptor {len[15:0], addr[31:0]}
//   i_full_pBufWR         pBufWR FIFO full
//   o_wren_pBufWR         registered FIFO write strobe
//   o_din_pBufWR          registered FIFO write data
//   i_cmpl_valid/addr     engine finished writing the buffer at addr
//   i_rel_valid           CPU frees the oldest filled slot
//   o_filled_cnt          slots holding packets not yet released
//   o_busy                engine not idle
//   o_drained             one-cycle pulse when drain completes
//   o_err                 sticky protocol error
//
// Configuration macro DMA_RXBUF_STAT_EN adds saturating event counters
// o_stat_post (engine posts) and o_stat_err (error events).
module dma_rxbuf_sched #(
  parameter int          SLOT_NUM   = 8,
  parameter logic [31:0] BUF_BASE   = 32'h0010_0000,
  parameter int          BUF_STRIDE = 2048,
  parameter logic [15:0] BUF_LEN    = 16'd1536,
  parameter int          CREDIT     = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_cpu_wren_pBufWR,
  input  logic [47:0] i_cpu_din_pBufWR,
  input  logic        i_full_pBufWR,
  output logic        o_wren_pBufWR,
  output logic [47:0] o_din_pBufWR,
  input  logic        i_cmpl_valid,
  input  logic [31:0] i_cmpl_addr,
  input  logic        i_rel_valid,
  output logic [6:0]  o_filled_cnt,
  output logic        o_busy,
  output logic        o_drained,
  output logic        o_err
`ifdef DMA_RXBUF_STAT_EN
  ,
  output logic [15:0] o_stat_post,
  output logic [15:0] o_stat_err
`endif
);

  localparam int PW = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;
  localparam int SW = $clog2(BUF_STRIDE);
  localparam logic [6:0]    SLOT_C   = 7'(SLOT_NUM);
  localparam logic [6:0]    CREDIT_C = 7'(CREDIT);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        state_r, state_nx_s;
  logic [PW-1:0] post_ptr_r, cmpl_ptr_r, rel_ptr_r;
  logic [6:0]    n_out_r, n_fill_r, used_s;
  logic          wren_r, err_r, drained_r;
  logic [47:0]   din_r;
  logic          cpu_ok_s, cpu_drop_s, post_s;
  logic          cmpl_ok_s, cmpl_bad_s, rel_ok_s, rel_bad_s, drain_done_s;

  // Byte address of a ring slot.
  function automatic logic [31:0] slot_addr(input logic [PW-1:0] ptr);
    return BUF_BASE + ({{(32-PW){1'b0}}, ptr} << SW);
  endfunction

  // A completion must name exactly the oldest outstanding slot; addresses below
  // the base wrap to huge offsets and therefore never match.
  function automatic logic cmpl_match(input logic [31:0] addr, input logic [PW-1:0] ptr);
    logic [31:0] diff;
    diff = addr - BUF_BASE;
    return (diff[SW-1:0] == {SW{1'b0}}) &&
           (diff[31:SW] == {{(32-SW-PW){1'b0}}, ptr});
  endfunction

  // Per-cycle decisions: arbitration, post eligibility, completion/release checks.
  always_comb begin
    used_s       = n_out_r + n_fill_r;
    cpu_ok_s     = i_cpu_wren_pBufWR && !i_full_pBufWR;
    cpu_drop_s   = i_cpu_wren_pBufWR && i_full_pBufWR;
    // Gating on i_enable as well as RUN stops posting in the very cycle the
    // engine is disabled.
    if ((state_r == ST_RUN) && i_enable && (used_s < SLOT_C) && (n_out_r < CREDIT_C) &&
        !i_full_pBufWR && !i_cpu_wren_pBufWR) begin
      post_s = 1'b1;
    end else begin
      post_s = 1'b0;
    end
    cmpl_ok_s    = i_cmpl_valid && (n_out_r != 7'd0) && cmpl_match(i_cmpl_addr, cmpl_ptr_r);
    cmpl_bad_s   = i_cmpl_valid && !cmpl_ok_s;
    rel_ok_s     = i_rel_valid && (n_fill_r != 7'd0);
    rel_bad_s    = i_rel_valid && (n_fill_r == 7'd0);
    drain_done_s = (state_r == ST_DRAIN) && !i_enable && (n_out_r == 7'd0);
  end

  // Next-state logic for the refill engine.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_enable) state_nx_s = ST_RUN;
        else          state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!i_enable) state_nx_s = ST_DRAIN;
        else           state_nx_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (i_enable)               state_nx_s = ST_RUN;
        else if (n_out_r == 7'd0)   state_nx_s = ST_IDLE;
        else                        state_nx_s = ST_DRAIN;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, ring pointers, counters and registered FIFO write port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      post_ptr_r <= {PW{1'b0}};
      cmpl_ptr_r <= {PW{1'b0}};
      rel_ptr_r  <= {PW{1'b0}};
      n_out_r    <= 7'd0;
      n_fill_r   <= 7'd0;
      wren_r     <= 1'b0;
      din_r      <= 48'b0;
      err_r      <= 1'b0;
      drained_r  <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      wren_r    <= cpu_ok_s || post_s;
      drained_r <= drain_done_s;
      if (cpu_ok_s)    din_r <= i_cpu_din_pBufWR;
      else if (post_s) din_r <= {BUF_LEN, slot_addr(post_ptr_r)};
      else             din_r <= din_r;
      if (post_s)    post_ptr_r <= post_ptr_r + PTR_ONE;
      else           post_ptr_r <= post_ptr_r;
      if (cmpl_ok_s) cmpl_ptr_r <= cmpl_ptr_r + PTR_ONE;
      else           cmpl_ptr_r <= cmpl_ptr_r;
      if (rel_ok_s)  rel_ptr_r  <= rel_ptr_r + PTR_ONE;
      else           rel_ptr_r  <= rel_ptr_r;
      // Net update: post, completion and release may all land in one cycle.
      n_out_r  <= n_out_r + {6'd0, post_s} - {6'd0, cmpl_ok_s};
      n_fill_r <= n_fill_r + {6'd0, cmpl_ok_s} - {6'd0, rel_ok_s};
      err_r    <= err_r || cpu_drop_s || cmpl_bad_s || rel_bad_s;
    end
  end

  assign o_wren_pBufWR = wren_r;
  assign o_din_pBufWR  = din_r;
  assign o_filled_cnt  = n_fill_r;
  assign o_busy        = (state_r != ST_IDLE);
  assign o_drained     = drained_r;
  assign o_err         = err_r;

`ifdef DMA_RXBUF_STAT_EN
  logic [15:0] stat_post_r, stat_err_r;
  logic [16:0] err_sum_s;
  logic [1:0]  err_evt_s;

  // Several error sources can fire together; add them all, then saturate.
  always_comb begin
    err_evt_s = {1'b0, cpu_drop_s} + {1'b0, cmpl_bad_s} + {1'b0, rel_bad_s};
    err_sum_s = {1'b0, stat_err_r} + {15'd0, err_evt_s};
  end

  // Saturating event counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_post_r <= 16'd0;
      stat_err_r  <= 16'd0;
    end else begin
      if (post_s && (stat_post_r != 16'hFFFF)) stat_post_r <= stat_post_r + 16'd1;
      else                                     stat_post_r <= stat_post_r;
      if (err_sum_s[16]) stat_err_r <= 16'hFFFF;
      else               stat_err_r <= err_sum_s[15:0];
    end
  end

  assign o_stat_post = stat_post_r;
  assign o_stat_err  = stat_err_r;
`endif

endmodule

// File: tb/tb_dma_rxbuf_sched.sv
module tb_dma_rxbuf_sched;

  localparam int SLOT_NUM = 8;
  localparam int CREDIT   = 4;
  localparam logic [15:0] BUF_LEN = 16'h0600;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        cpu_wren = 1'b0;
  logic [47:0] cpu_din = 48'd0;
  logic        full = 1'b0;
  logic        wren;
  logic [47:0] din;
  logic        cmpl_valid = 1'b0;
  logic [31:0] cmpl_addr = 32'd0;
  logic        rel_valid = 1'b0;
  logic [6:0]  filled;
  logic        busy, drained, err;
`ifdef DMA_RXBUF_STAT_EN
  logic [15:0] stat_post, stat_err;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: ring contents as queues of slot indices.
  int          q_out[$];
  int          q_fill[$];
  int          next_slot;
  int          m_st;
  logic        exp_wren, exp_err, exp_drained;
  logic [47:0] exp_din;
  logic [47:0] got_q[$];
  int          drn_seen;

  dma_rxbuf_sched dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en),
    .i_cpu_wren_pBufWR(cpu_wren), .i_cpu_din_pBufWR(cpu_din),
    .i_full_pBufWR(full), .o_wren_pBufWR(wren), .o_din_pBufWR(din),
    .i_cmpl_valid(cmpl_valid), .i_cmpl_addr(cmpl_addr), .i_rel_valid(rel_valid),
    .o_filled_cnt(filled), .o_busy(busy), .o_drained(drained), .o_err(err)
`ifdef DMA_RXBUF_STAT_EN
    , .o_stat_post(stat_post), .o_stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slot_addr(input int s);
    return 32'h0010_0000 + 32'(s) * 32'd2048;
  endfunction

  // One clock: model decides from the current inputs, then both advance.
  task automatic tick();
    bit cpu_ok, post, c_ok, r_ok, err_ev, drn;
    int nxt;
    logic [47:0] cdin;
    cdin   = cpu_din;
    cpu_ok = cpu_wren && !full;
    post   = (m_st == M_RUN) && en && (q_out.size() + q_fill.size() < SLOT_NUM) &&
             (q_out.size() < CREDIT) && !full && !cpu_wren;
    c_ok = 1'b0;
    if (cmpl_valid && q_out.size() > 0) c_ok = (cmpl_addr == slot_addr(q_out[0]));
    r_ok   = rel_valid && (q_fill.size() > 0);
    err_ev = (cpu_wren && full) || (cmpl_valid && !c_ok) || (rel_valid && !r_ok);
    drn    = (m_st == M_DRAIN) && !en && (q_out.size() == 0);
    nxt = m_st;
    if (m_st == M_IDLE && en) nxt = M_RUN;
    else if (m_st == M_RUN && !en) nxt = M_DRAIN;
    else if (m_st == M_DRAIN && en) nxt = M_RUN;
    else if (m_st == M_DRAIN && q_out.size() == 0) nxt = M_IDLE;
    @(posedge clk);
    exp_wren = cpu_ok || post;
    if (cpu_ok) exp_din = cdin;
    else if (post) exp_din = {BUF_LEN, slot_addr(next_slot)};
    if (r_ok) void'(q_fill.pop_front());
    if (c_ok) q_fill.push_back(q_out.pop_front());
    if (post) begin
      q_out.push_back(next_slot);
      next_slot = (next_slot + 1) % SLOT_NUM;
    end
    exp_err     = exp_err || err_ev;
    exp_drained = drn;
    m_st        = nxt;
    #1;
    if (wren) got_q.push_back(din);
    if (drained) drn_seen++;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cpu_wren = 1'b0; full = 1'b0;
    cmpl_valid = 1'b0; rel_valid = 1'b0;
    @(posedge clk);
    #1;
    q_out.delete(); q_fill.delete(); got_q.delete();
    next_slot = 0; m_st = M_IDLE; drn_seen = 0;
    exp_wren = 1'b0; exp_err = 1'b0; exp_drained = 1'b0; exp_din = 48'd0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    en = 1'b1;
    repeat (6) tick();
    do_reset();
    n_total += 6;
    if (wren !== 1'b0)    begin n_bad++; $display("FAIL reset_wren got=%b want=0", wren); end
    if (din !== 48'd0)    begin n_bad++; $display("FAIL reset_din got=%h want=0", din); end
    if (filled !== 7'd0)  begin n_bad++; $display("FAIL reset_filled got=%0d want=0", filled); end
    if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (drained !== 1'b0) begin n_bad++; $display("FAIL reset_drained got=%b want=0", drained); end
    if (err !== 1'b0)     begin n_bad++; $display("FAIL reset_err got=%b want=0", err); end
  endtask

  task automatic test_refill();
    logic [31:0] want_a[4];
    want_a[0] = 32'h0010_0000; want_a[1] = 32'h0010_0800;
    want_a[2] = 32'h0010_1000; want_a[3] = 32'h0010_1800;
    do_reset();
    en = 1'b1;
    repeat (10) tick();
    n_total++;
    if (got_q.size() != 4) begin n_bad++; $display("FAIL refill_count got=%0d want=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== {16'h0600, want_a[i]}) begin
        n_bad++; $display("FAIL refill_desc%0d got=%h want=%h", i, got_q[i], {16'h0600, want_a[i]});
      end
    end
    cmpl_valid = 1'b1; cmpl_addr = 32'h0010_0000;
    tick();
    cmpl_valid = 1'b0;
    got_q.delete();
    repeat (3) tick();
    n_total += 2;
    if (got_q.size() != 1 || got_q[0] !== {16'h0600, 32'h0010_2000}) begin
      n_bad++; $display("FAIL fifth_post got_n=%0d got=%h want=%h", got_q.size(),
                        (got_q.size() > 0) ? got_q[0] : 48'd0, {16'h0600, 32'h0010_2000});
    end
    if (filled !== 7'd1) begin n_bad++; $display("FAIL filled_one got=%0d want=1", filled); end
    rel_valid = 1'b1;
    tick();
    rel_valid = 1'b0;
    n_total += 2;
    if (filled !== 7'd0) begin n_bad++; $display("FAIL filled_released got=%0d want=0", filled); end
    if (err !== 1'b0)    begin n_bad++; $display("FAIL release_err got=%b want=0", err); end
  endtask

  task automatic test_wrap();
    int budget;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      budget = 0;
      while (q_out.size() == 0 && budget < 20) begin tick(); budget++; end
      if (q_out.size() == 0) begin
        n_total++; n_bad++; $display("FAIL wrap_timeout got=no_post want=post k=%0d", k);
        break;
      end
      cmpl_valid = 1'b1; cmpl_addr = slot_addr(q_out[0]);
      tick();
      cmpl_valid = 1'b0;
    end
    got_q.delete();
    repeat (6) tick();
    n_total += 2;
    if (filled !== 7'd8)   begin n_bad++; $display("FAIL wrap_filled got=%0d want=8", filled); end
    if (got_q.size() != 0) begin n_bad++; $display("FAIL wrap_noposts got=%0d want=0", got_q.size()); end
    rel_valid = 1'b1;
    tick();
    rel_valid = 1'b0;
    repeat (4) tick();
    n_total++;
    if (got_q.size() != 1 || got_q[0] !== {16'h0600, 32'h0010_0000}) begin
      n_bad++; $display("FAIL wrap_post got_n=%0d got=%h want=%h", got_q.size(),
                        (got_q.size() > 0) ? got_q[0] : 48'd0, {16'h0600, 32'h0010_0000});
    end
  endtask

  task automatic test_cpu_arb();
    do_reset();
    en = 1'b1;
    tick();
    cpu_wren = 1'b1; cpu_din = {16'h0040, 32'h0020_0000};
    tick();
    cpu_wren = 1'b0;
    n_total++;
    if (wren !== 1'b1 || din !== {16'h0040, 32'h0020_0000}) begin
      n_bad++; $display("FAIL cpu_first got=%b/%h want=1/%h", wren, din, {16'h0040, 32'h0020_0000});
    end
    tick();
    n_total++;
    if (wren !== 1'b1 || din !== {16'h0600, 32'h0010_0000}) begin
      n_bad++; $display("FAIL engine_after_cpu got=%b/%h want=1/%h", wren, din, {16'h0600, 32'h0010_0000});
    end
    full = 1'b1; cpu_wren = 1'b1; cpu_din = {16'h0040, 32'h0020_0800};
    tick();
    cpu_wren = 1'b0; full = 1'b0;
    n_total += 2;
    if (wren !== 1'b0) begin n_bad++; $display("FAIL cpu_full_wren got=%b want=0", wren); end
    if (err !== 1'b1)  begin n_bad++; $display("FAIL cpu_full_err got=%b want=1", err); end
  endtask

  task automatic test_bad_events();
    do_reset();
    en = 1'b1;
    repeat (3) tick();
    cmpl_valid = 1'b1; cmpl_addr = 32'h0010_0800;
    tick();
    cmpl_valid = 1'b0;
    n_total += 2;
    if (err !== 1'b1)    begin n_bad++; $display("FAIL ooo_cmpl_err got=%b want=1", err); end
    if (filled !== 7'd0) begin n_bad++; $display("FAIL ooo_cmpl_filled got=%0d want=0", filled); end
    do_reset();
    rel_valid = 1'b1;
    tick();
    rel_valid = 1'b0;
    n_total++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL empty_rel_err got=%b want=1", err); end
  endtask

  task automatic test_drain();
    int budget;
    do_reset();
    en = 1'b1;
    repeat (8) tick();
    full = 1'b1;
    cmpl_valid = 1'b1; cmpl_addr = 32'h0010_0000;
    tick();
    cmpl_valid = 1'b0;
    en = 1'b0; full = 1'b0;
    got_q.delete();
    repeat (3) tick();
    n_total += 2;
    if (busy !== 1'b1)     begin n_bad++; $display("FAIL drain_busy got=%b want=1", busy); end
    if (got_q.size() != 0) begin n_bad++; $display("FAIL drain_noposts got=%0d want=0", got_q.size()); end
    drn_seen = 0;
    for (int k = 0; k < 3; k++) begin
      cmpl_valid = 1'b1; cmpl_addr = slot_addr(k + 1);
      tick();
      cmpl_valid = 1'b0;
      tick();
    end
    budget = 0;
    while (busy && budget < 10) begin tick(); budget++; end
    repeat (3) tick();
    n_total += 3;
    if (busy !== 1'b0)  begin n_bad++; $display("FAIL drain_idle got=%b want=0", busy); end
    if (drn_seen != 1)  begin n_bad++; $display("FAIL drained_pulses got=%0d want=1", drn_seen); end
    if (err !== 1'b0)   begin n_bad++; $display("FAIL drain_err got=%b want=0", err); end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 2; seg++) begin
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        en       = ($urandom_range(0, 15) != 0);
        full     = ($urandom_range(0, 5) == 0);
        cpu_wren = ($urandom_range(0, 9) == 0);
        cpu_din  = {$urandom(), $urandom()};
        rel_valid = ($urandom_range(0, 4) == 0);
        cmpl_valid = ($urandom_range(0, 2) == 0);
        if (q_out.size() > 0 && $urandom_range(0, 60) != 0) cmpl_addr = slot_addr(q_out[0]);
        else cmpl_addr = slot_addr($urandom_range(0, 7)) + (($urandom_range(0, 1) == 1) ? 32'd4 : 32'd0);
        if (seg == 0 && c < 700 && q_out.size() == 0) cmpl_valid = 1'b0;
        tick();
        n_total += 5;
        if (wren !== exp_wren) begin n_bad++; $display("FAIL rnd_wren c=%0d got=%b want=%b", c, wren, exp_wren); end
        if (exp_wren && din !== exp_din) begin n_bad++; $display("FAIL rnd_din c=%0d got=%h want=%h", c, din, exp_din); end
        if (filled !== 7'(q_fill.size())) begin n_bad++; $display("FAIL rnd_filled c=%0d got=%0d want=%0d", c, filled, q_fill.size()); end
        if (err !== exp_err) begin n_bad++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, err, exp_err); end
        if (busy !== (m_st != M_IDLE) || drained !== exp_drained) begin
          n_bad++; $display("FAIL rnd_state c=%0d got=%b/%b want=%b/%b", c, busy, drained, (m_st != M_IDLE), exp_drained);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_wrap();
    test_cpu_arb();
    test_bad_events();
    test_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
